frame_scheduler: RTL and testbench
==================================

// Module: frame_scheduler
// PURPOSE
//  Buffers the incoming audio sample stream in a circular RAM and cuts it into overlapping frames.
//  Sequences the Hamming window stage: start pulse, one frame streamed at one sample per cycle,
//  then waits for its done and advances the frame base by HOP.
//  Sits between the audio input FIFO and the Hamming window, gated by FFT readiness.
// PARAMETERS
//  SAMPLE_WIDTH  16   audio sample width (signed)
//  FRAME_LEN     306  samples per frame; must equal the Hamming coefficient count
//  HOP           153  frame advance in samples; 1 <= HOP <= FRAME_LEN
//  BUF_DEPTH     512  circular buffer depth; power of 2, >= FRAME_LEN + HOP
//  CNT_WIDTH     16   width of frame_count_o
// PORTS
//  clk                  in   1             clock
//  rst_n                in   1             asynchronous active-low reset
//  enable_i             in   1             1 = may start new frames; 0 = finish current frame, then hold
//  sample_i             in   SAMPLE_WIDTH  audio sample in
//  sample_valid_i       in   1             sample_i valid
//  sample_ready_o       out  1             buffer can accept (fill < BUF_DEPTH)
//  fft_ready_i          in   1             downstream can accept a new windowed frame
//  hw_start_o           out  1             1-cycle start pulse to the Hamming window
//  hw_valid_to_read_o   out  1             hw_frame_sample_o valid this cycle
//  hw_frame_sample_o    out  SAMPLE_WIDTH  frame sample to the Hamming window
//  hw_rd_en_i           in   1             Hamming read acknowledge (1 per consumed sample)
//  hw_done_i            in   1             Hamming frame complete
//  busy_o               out  1             state != IDLE
//  frame_count_o        out  CNT_WIDTH     frames completed, wraps
//  err_o                out  1             sticky protocol error
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; wr_ptr/base_ptr/fill/frame_count = 0; all outputs 0
//   except sample_ready_o = 1 after reset release. RAM contents are not reset.
//  Write side: a sample is accepted when sample_valid_i & sample_ready_o.
//   It is stored at wr_ptr, then wr_ptr+1 mod BUF_DEPTH and fill+1.
//  fill update with a simultaneous write and advance: fill_next = fill + wr - (adv ? HOP : 0).
//   Never underflows, because adv requires fill >= FRAME_LEN >= HOP.
//  RAM: 1 write port, 1 synchronous read port (1-cycle latency).
//  FSM:
//   IDLE     -> START when enable_i & fft_ready_i & fill >= FRAME_LEN.
//   START    hw_start_o = 1 for exactly this cycle; rd_idx = 0; -> STREAM.
//   STREAM   issue read address base_ptr + rd_idx (mod BUF_DEPTH), rd_idx++ each cycle.
//            hw_valid_to_read_o and hw_frame_sample_o follow the address by 1 cycle.
//            Gives exactly FRAME_LEN consecutive valid cycles, no bubbles, oldest sample first.
//            -> WAIT_DONE after the last valid cycle.
//   WAIT_DONE on hw_done_i -> ADVANCE.
//   ADVANCE  base_ptr += HOP (mod BUF_DEPTH); fill -= HOP; frame_count++; -> IDLE.
//  First valid sample appears 2 cycles after hw_start_o. Frame-to-frame gap is at least 2 idle cycles.
//  hw_rd_en_i pulses are counted per frame; the counter clears in START.
//   In ADVANCE, count != FRAME_LEN sets err_o.
//  hw_done_i asserted outside WAIT_DONE sets err_o and is otherwise ignored.
//  err_o clears only on reset.
//  enable_i / fft_ready_i are sampled only in IDLE; deasserting them mid-frame has no effect.
//  Buffer full (fill == BUF_DEPTH): sample_ready_o = 0 and input stalls; no data is lost.
//  Write pointer wrap and read address wrap are both mod BUF_DEPTH.
//   The frame region never aliases unread input because writes target only free slots.
// TESTING
//  1 Reset: rst_n=0 mid-STREAM -> outputs 0 immediately; after release fill=0, sample_ready_o=1.
//  2 Ramp 0,1,2,... with fft_ready_i=1 -> no start at 305 samples; start 1 cycle after the 306th;
//    306 consecutive valid cycles carrying 0..305.
//  3 Hop: continue the ramp, ack with 306 rd_en, pulse done -> frame_count_o=1;
//    2nd frame carries 153..458; 4th frame crosses the 512 wrap correctly.
//  4 Backpressure: fft_ready_i=0, stream 600 samples -> sample_ready_o falls at fill=512; no start;
//    raise fft_ready_i -> frame 0..305.
//  5 Protocol error: 305 rd_en then done -> err_o=1 and stays 1; done pulse during STREAM -> err_o=1.
//  6 Simultaneous write and ADVANCE in the same cycle -> fill = old + 1 - 153 exactly.

Source files
------------

// File: rtl/frame_scheduler.sv
// Circular sample buffer that cuts the input stream into overlapping frames and
// sequences the Hamming window stage: start pulse, stream one frame, await done, hop.
module frame_scheduler #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int FRAME_LEN    = 306,
   parameter int HOP          = 153,
   parameter int BUF_DEPTH    = 512,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable_i,
   input  logic [SAMPLE_WIDTH-1:0] sample_i,
   input  logic                    sample_valid_i,
   output logic                    sample_ready_o,
   input  logic                    fft_ready_i,
   output logic                    hw_start_o,
   output logic                    hw_valid_to_read_o,
   output logic [SAMPLE_WIDTH-1:0] hw_frame_sample_o,
   input  logic                    hw_rd_en_i,
   input  logic                    hw_done_i,
   output logic                    busy_o,
   output logic [CNT_WIDTH-1:0]    frame_count_o,
   output logic                    err_o
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int FW = PW + 1;
   localparam int AW = $clog2(FRAME_LEN + 1) + 1;

   localparam logic [FW-1:0] FRAME_LEN_F = FW'(FRAME_LEN);
   localparam logic [FW-1:0] HOP_F       = FW'(HOP);
   localparam logic [FW-1:0] DEPTH_F     = FW'(BUF_DEPTH);
   localparam logic [PW-1:0] HOP_P       = PW'(HOP);
   localparam logic [PW-1:0] LAST_IDX    = PW'(FRAME_LEN - 1);
   localparam logic [AW-1:0] FRAME_LEN_A = AW'(FRAME_LEN);
   localparam logic [AW-1:0] ACK_MAX     = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_STREAM, S_WAIT_DONE, S_ADVANCE
   } state_t;

   state_t                  state_q, state_d;
   logic [SAMPLE_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PW-1:0]           wr_ptr_q, base_ptr_q, rd_idx_q, rd_idx_d, rd_addr;
   logic [FW-1:0]           fill_q, fill_d;
   logic [AW-1:0]           ack_cnt_q, ack_cnt_d;
   logic [CNT_WIDTH-1:0]    frame_cnt_q;
   logic [SAMPLE_WIDTH-1:0] rd_data_q;
   logic                    ready_q, valid_q, err_q, err_d;
   logic                    wr_en, adv, rd_en;

   // Handshake: a sample transfers on a cycle where sample_valid_i and sample_ready_o
   // are both high; ready is registered and only drops when the buffer is full.
   assign wr_en   = sample_valid_i & ready_q;
   assign adv     = (state_q == S_ADVANCE);
   assign rd_en   = (state_q == S_STREAM);
   assign rd_addr = base_ptr_q + rd_idx_q;
   assign fill_d  = fill_q + {{(FW-1){1'b0}}, wr_en} - (adv ? HOP_F : '0);

   always_comb begin
      state_d   = state_q;
      rd_idx_d  = rd_idx_q;
      ack_cnt_d = ack_cnt_q;
      err_d     = err_q;
      case (state_q)
         // fill_d includes a sample landing this cycle, so the start follows it directly
         S_IDLE:      if (enable_i && fft_ready_i && fill_d >= FRAME_LEN_F) state_d = S_START;
         S_START: begin
            rd_idx_d  = '0;
            ack_cnt_d = '0;
            state_d   = S_STREAM;
         end
         S_STREAM: begin
            rd_idx_d = rd_idx_q + 1'b1;
            if (rd_idx_q == LAST_IDX) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: if (hw_done_i) state_d = S_ADVANCE;
         S_ADVANCE: begin
            if (ack_cnt_q != FRAME_LEN_A) err_d = 1'b1;
            state_d = S_IDLE;
         end
         default:     state_d = S_IDLE;
      endcase
      if ((state_q == S_STREAM || state_q == S_WAIT_DONE) && hw_rd_en_i && ack_cnt_q != ACK_MAX)
         ack_cnt_d = ack_cnt_q + 1'b1;
      if (hw_done_i && state_q != S_WAIT_DONE) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         base_ptr_q  <= '0;
         rd_idx_q    <= '0;
         fill_q      <= '0;
         ack_cnt_q   <= '0;
         frame_cnt_q <= '0;
         ready_q     <= 1'b0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_q + {{(PW-1){1'b0}}, wr_en};
         base_ptr_q  <= adv ? base_ptr_q + HOP_P : base_ptr_q;
         rd_idx_q    <= rd_idx_d;
         fill_q      <= fill_d;
         ack_cnt_q   <= ack_cnt_d;
         frame_cnt_q <= frame_cnt_q + {{(CNT_WIDTH-1){1'b0}}, adv};
         ready_q     <= (fill_d < DEPTH_F);
         valid_q     <= rd_en;
         err_q       <= err_d;
      end
   end

   // Writes only target free slots, so they never collide with the frame being read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= sample_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data_q <= '0;
      else if (rd_en) rd_data_q <= mem[rd_addr];
   end

   assign sample_ready_o     = ready_q;
   assign hw_start_o         = (state_q == S_START);
   assign hw_valid_to_read_o = valid_q;
   assign hw_frame_sample_o  = rd_data_q;
   assign busy_o             = (state_q != S_IDLE);
   assign frame_count_o      = frame_cnt_q;
   assign err_o              = err_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: stream-level reference model (every accepted sample kept in
// order, frame k = samples k*HOP .. k*HOP+FRAME_LEN-1), fill-level vectors and corner sequences.
module tb_frame_scheduler;

   localparam int SW = 16, FL = 306, HOP = 153, DEPTH = 512, CW = 16;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          enable_i = 1'b0, sample_valid_i = 1'b0, fft_ready_i = 1'b0;
   logic          hw_rd_en_i = 1'b0, hw_done_i = 1'b0;
   logic [SW-1:0] sample_i = '0;
   logic          sample_ready_o, hw_start_o, hw_valid_to_read_o, busy_o, err_o;
   logic [SW-1:0] hw_frame_sample_o;
   logic [CW-1:0] frame_count_o;

   always #5 clk = ~clk;

   frame_scheduler #(.SAMPLE_WIDTH(SW), .FRAME_LEN(FL), .HOP(HOP), .BUF_DEPTH(DEPTH),
                     .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .sample_i(sample_i),
      .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
      .fft_ready_i(fft_ready_i), .hw_start_o(hw_start_o),
      .hw_valid_to_read_o(hw_valid_to_read_o), .hw_frame_sample_o(hw_frame_sample_o),
      .hw_rd_en_i(hw_rd_en_i), .hw_done_i(hw_done_i), .busy_o(busy_o),
      .frame_count_o(frame_count_o), .err_o(err_o)
   );

   int n_cmp = 0, n_fail = 0;

   // reference model state
   logic [SW-1:0] exp_q[$];
   int exp_frames, cyc_ss, acks;
   bit active, in_adv, exp_err;

   // stimulus / responder controls
   int src_mode, done_delay;
   bit auto_ack, drop_ack, auto_done, rand_ctl;

   typedef struct {
      int   pushes;
      logic fft;
      logic exp_ready;
      logic exp_busy;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_fill();
      return exp_q.size() - HOP * exp_frames;
   endfunction

   // One clock: model predicts from pre-edge inputs, outputs are checked #1 after the edge,
   // then the source and the Hamming responder drive the next cycle.
   task automatic tick();
      bit acc, start_now, pre_wait, pre_ack, pre_done, pre_adv, pre_active, exp_valid;
      logic [SW-1:0] s;
      acc        = sample_valid_i && sample_ready_o;
      s          = sample_i;
      start_now  = !active && enable_i && fft_ready_i && (model_fill() + int'(acc) >= FL);
      pre_active = active;
      pre_adv    = in_adv;
      pre_wait   = active && !in_adv && cyc_ss >= FL + 1;
      pre_ack    = hw_rd_en_i;
      pre_done   = hw_done_i;
      @(posedge clk);
      #1;
      if (acc) exp_q.push_back(s);
      if (pre_active && !pre_adv && cyc_ss >= 1 && pre_ack) acks++;
      if (pre_adv) begin
         exp_frames++;
         if (acks != FL) exp_err = 1'b1;
         active = 1'b0;
         in_adv = 1'b0;
      end else if (pre_done && pre_wait) begin
         in_adv = 1'b1;
      end
      if (pre_done && !pre_wait) exp_err = 1'b1;
      if (start_now) begin
         active = 1'b1;
         cyc_ss = 0;
         acks   = 0;
         if (rand_ctl) done_delay = $urandom_range(0, 3);
      end else if (active && !in_adv) begin
         cyc_ss++;
      end

      chk("hw_start", hw_start_o, start_now);
      chk("busy", busy_o, active);
      chk("err", err_o, exp_err);
      chk("frame_count", frame_count_o, exp_frames[CW-1:0]);
      chk("sample_ready", sample_ready_o, model_fill() < DEPTH);
      exp_valid = active && !in_adv && cyc_ss >= 2 && cyc_ss <= FL + 1;
      chk("hw_valid", hw_valid_to_read_o, exp_valid);
      if (exp_valid && hw_valid_to_read_o)
         chk("frame_sample", hw_frame_sample_o, exp_q[exp_frames * HOP + cyc_ss - 2]);

      hw_rd_en_i = auto_ack && hw_valid_to_read_o && !(drop_ack && cyc_ss == 2);
      hw_done_i  = auto_done && active && !in_adv && (cyc_ss == FL + 1 + done_delay);
      if (rand_ctl) begin
         enable_i    = ($urandom_range(0, 7) != 0);
         fft_ready_i = ($urandom_range(0, 7) != 0);
      end
      case (src_mode)
         1: begin sample_valid_i = 1'b1; sample_i = SW'(exp_q.size()); end
         2: begin sample_valid_i = ($urandom_range(0, 3) != 0); sample_i = SW'($urandom); end
         default: sample_valid_i = 1'b0;
      endcase
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sample_valid_i = 1'b0; hw_rd_en_i = 1'b0; hw_done_i = 1'b0;
      enable_i = 1'b0; fft_ready_i = 1'b0;
      src_mode = 0; auto_ack = 1'b1; drop_ack = 1'b0; auto_done = 1'b1; rand_ctl = 1'b0;
      done_delay = 1;
      exp_q.delete();
      exp_frames = 0; cyc_ss = 0; acks = 0;
      active = 1'b0; in_adv = 1'b0; exp_err = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic start_ramp();
      enable_i = 1'b1; fft_ready_i = 1'b1;
      src_mode = 1; sample_valid_i = 1'b1; sample_i = SW'(exp_q.size());
   endtask

   task automatic run_frames(input int n, input int budget);
      int c = 0;
      while (exp_frames < n && c < budget) begin
         tick();
         c++;
      end
      chk("frames_reached", frame_count_o, n);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      vecs[0] = '{305, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{306, 1'b1, 1'b1, 1'b1};
      vecs[2] = '{306, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{511, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{512, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{600, 1'b0, 1'b0, 1'b0};

      // fill-level vectors; the last one (full buffer) then releases fft_ready_i
      foreach (vecs[i]) begin
         do_reset();
         start_ramp();
         fft_ready_i = vecs[i].fft;
         repeat (vecs[i].pushes) tick();
         src_mode = 0;
         sample_valid_i = 1'b0;
         chk($sformatf("vec%0d_ready", i), sample_ready_o, vecs[i].exp_ready);
         chk($sformatf("vec%0d_busy", i), busy_o, vecs[i].exp_busy);
      end
      fft_ready_i = 1'b1;
      tick();
      chk("full_then_start", hw_start_o, 1);
      run_frames(1, 1000);

      // ramp: start right after the 306th sample, then four frames across the wrap
      do_reset();
      start_ramp();
      done_delay = 0;
      repeat (305) tick();
      chk("no_start_305", busy_o, 0);
      tick();
      chk("start_after_306", hw_start_o, 1);
      run_frames(4, 4000);

      // write in the same cycle as ADVANCE leaves fill at 457 + 1 - 153 = 305
      do_reset();
      start_ramp();
      done_delay = 5;
      repeat (306) tick();
      repeat (151) tick();
      src_mode = 0;
      sample_valid_i = 1'b0;
      c = 0;
      while (!in_adv && c < 1000) begin
         tick();
         c++;
      end
      chk("reached_advance", busy_o && in_adv, 1);
      sample_valid_i = 1'b1;
      sample_i = SW'(exp_q.size());
      tick();
      sample_valid_i = 1'b0;
      chk("adv_frame_count", frame_count_o, 1);
      repeat (4) tick();
      chk("no_start_fill305", busy_o, 0);
      sample_valid_i = 1'b1;
      sample_i = SW'(exp_q.size());
      tick();
      sample_valid_i = 1'b0;
      chk("start_fill306", hw_start_o, 1);
      run_frames(2, 1000);

      // one missing read acknowledge, error stays sticky
      do_reset();
      start_ramp();
      drop_ack = 1'b1;
      done_delay = 2;
      run_frames(1, 2000);
      chk("err_short_ack", err_o, 1);
      drop_ack = 1'b0;
      run_frames(2, 2000);
      chk("err_sticky", err_o, 1);

      // done during STREAM flags an error but does not end the frame
      do_reset();
      start_ramp();
      repeat (306 + 20) tick();
      hw_done_i = 1'b1;
      tick();
      chk("err_done_in_stream", err_o, 1);
      run_frames(1, 2000);

      // asynchronous reset in the middle of a frame
      do_reset();
      start_ramp();
      repeat (306 + 50) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", sample_ready_o, 0);
      chk("rst_start", hw_start_o, 0);
      chk("rst_valid", hw_valid_to_read_o, 0);
      chk("rst_sample", hw_frame_sample_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_count", frame_count_o, 0);
      chk("rst_err", err_o, 0);
      do_reset();
      chk("ready_after_reset", sample_ready_o, 1);

      // random traffic, enables and done latency
      do_reset();
      src_mode = 2;
      rand_ctl = 1'b1;
      repeat (6000) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
